// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and forwarding sequencer for a 5-stage pipeline, with a small wait/drain/halt FSM.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; branch flush, load-use bubble, halt entry
// MEM_WAIT | data memory busy, whole pipe frozen, wait counter running
// DRAIN    | halt seen, front end frozen, back end retiring older ops
// HALTED   | everything frozen until reset
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX     = 15,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_halt,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        br_taken,
  input  logic        dmem_busy,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  localparam logic [7:0] LP_WAIT_MAX   = 8'(WAIT_MAX);
  localparam logic [2:0] LP_DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_wait_cnt, w_wait_nxt, w_wait_inc;
  logic [2:0] r_drain_cnt, w_drain_nxt;
  logic       r_mem_timeout, w_timeout_set;
  logic       w_load_use;

  // Run-rule results, reused when MEM_WAIT releases and when a branch cancels DRAIN
  logic [4:0] w_run_en;
  logic [2:0] w_run_fl;
  state_t     w_run_nxt;

  always_comb begin
    fwd_a = 2'b00;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
      fwd_a = 2'b10;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
      fwd_b = 2'b10;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
      fwd_b = 2'b01;
  end

  assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

  always_comb begin
    w_run_en  = 5'b11111;
    w_run_fl  = 3'b000;
    w_run_nxt = S_RUN;
    if (br_taken) begin
      w_run_fl = 3'b111;
    end else if (w_load_use) begin
      w_run_en = 5'b00111;
      w_run_fl = 3'b010;
    end else if (id_halt) begin
      w_run_en  = 5'b00111;
      w_run_fl  = 3'b010;
      w_run_nxt = S_DRAIN;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_drain_nxt   = r_drain_cnt;
    w_timeout_set = 1'b0;
    {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
    {if_id_flush, id_ex_flush, ex_mem_flush}           = 3'b000;
    case (r_state)
      S_RUN, S_MEM_WAIT: begin
        if (dmem_busy) begin
          w_state_nxt   = S_MEM_WAIT;
          w_wait_nxt    = (r_state == S_RUN) ? 8'd1 : w_wait_inc;
          w_timeout_set = (w_wait_nxt >= LP_WAIT_MAX);
        end else begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = w_run_en;
          {if_id_flush, id_ex_flush, ex_mem_flush}           = w_run_fl;
          w_state_nxt = w_run_nxt;
          w_wait_nxt  = 8'd0;
          w_drain_nxt = 3'd0;
        end
      end
      S_DRAIN: begin
        if (dmem_busy) begin
          w_state_nxt = S_DRAIN;
        end else if (br_taken) begin
          // Older taken branch wins: the halt was on the wrong path
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = w_run_en;
          {if_id_flush, id_ex_flush, ex_mem_flush}           = w_run_fl;
          w_state_nxt = S_RUN;
          w_drain_nxt = 3'd0;
        end else begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00111;
          {if_id_flush, id_ex_flush, ex_mem_flush}           = 3'b010;
          w_drain_nxt = r_drain_cnt + 3'd1;
          if (r_drain_cnt == LP_DRAIN_LAST)
            w_state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= 8'd0;
      r_drain_cnt   <= 3'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_timeout_set)
        r_mem_timeout <= 1'b1;
    end
  end

  assign state       = r_state;
  assign halted      = (r_state == S_HALTED);
  assign mem_timeout = r_mem_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  logic        w_stall, w_br_flush;

  assign w_stall    = ((r_state == S_RUN) || (r_state == S_MEM_WAIT)) && !pc_we;
  assign w_br_flush = br_taken && !dmem_busy && (r_state != S_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_br_flush)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int WAIT_MAX     = 15;
  localparam int DRAIN_CYCLES = 3;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, id_halt, ex_memread, mem_regwrite, wb_regwrite;
  logic br_taken, dmem_busy;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] fwd_a, fwd_b, state;
  logic halted, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_halt(id_halt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .halted(halted), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pipeline mode plus bookkeeping counts
  int          m_mode;
  int          m_wait;
  int          m_drained;
  bit          m_to;
  logic [31:0] m_stall, m_flush;

  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic       use1, use2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       memread;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       br;
    logic [4:0] exp_en;
    logic [2:0] exp_fl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_en();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we};
  endfunction

  function automatic logic [2:0] dut_fl();
    return {if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  function automatic bit lu_f();
    return ex_memread && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [1:0] fwd_f(input logic [4:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic exp_outputs(output logic [4:0] en, output logic [2:0] fl);
    en = 5'b11111;
    fl = 3'b000;
    if (m_mode == 3 || dmem_busy) en = 5'b00000;
    else if (br_taken) fl = 3'b111;
    else if (m_mode == 2 || lu_f() || id_halt) begin
      en = 5'b00111;
      fl = 3'b010;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_drained = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_next();
    logic [4:0] en;
    logic [2:0] fl;
    exp_outputs(en, fl);
    if ((m_mode == 0 || m_mode == 1) && !en[4]) m_stall++;
    if (m_mode != 3 && !dmem_busy && br_taken) m_flush++;
    if (m_mode == 3) begin
    end else if (dmem_busy) begin
      if (m_mode == 0) begin
        m_mode = 1;
        m_wait = 1;
      end else if (m_mode == 1) begin
        m_wait = (m_wait < 255) ? m_wait + 1 : 255;
      end
      if (m_mode == 1 && m_wait >= WAIT_MAX) m_to = 1;
    end else if (br_taken) begin
      m_mode = 0;
    end else if (m_mode == 2) begin
      m_drained++;
      if (m_drained == DRAIN_CYCLES) m_mode = 3;
    end else if (id_halt && !lu_f()) begin
      m_mode = 2;
      m_drained = 0;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic check_model();
    logic [4:0] en;
    logic [2:0] fl;
    exp_outputs(en, fl);
    chk("model_en", dut_en(), en);
    chk("model_flush", dut_fl(), fl);
    chk("model_fwd_a", fwd_a, fwd_f(ex_rs1));
    chk("model_fwd_b", fwd_b, fwd_f(ex_rs2));
    chk("model_state", state, m_mode);
    chk("model_halted", halted, (m_mode == 3));
    chk("model_timeout", mem_timeout, m_to);
`ifdef PIPE_PERF_CNT_EN
    chk("model_stall_cnt", stall_cnt, m_stall);
    chk("model_flush_cnt", flush_cnt, m_flush);
`else
    chk("stall_cnt_tied", stall_cnt, 32'd0);
    chk("flush_cnt_tied", flush_cnt, 32'd0);
`endif
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_halt = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    br_taken = 0; dmem_busy = 0;
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    check_model();
  endtask

  task automatic cyc_end();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_timeout", mem_timeout, 1'b0);
    chk("rst_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[1]  = '{0, 0, 0, 0,  7,  0, 0, 0,  7, 1,  7, 1, 0, 5'b11111, 3'b000, 2'b10, 2'b00};
    vecs[2]  = '{0, 0, 0, 0,  7,  0, 0, 0,  0, 1,  7, 1, 0, 5'b11111, 3'b000, 2'b01, 2'b00};
    vecs[3]  = '{0, 0, 0, 0,  0,  0, 0, 0,  0, 1,  0, 1, 0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[4]  = '{0, 0, 0, 0,  3,  9, 0, 0,  9, 0,  9, 1, 0, 5'b11111, 3'b000, 2'b00, 2'b01};
    vecs[5]  = '{0, 0, 0, 0, 12, 12, 0, 0, 12, 1,  4, 1, 0, 5'b11111, 3'b000, 2'b10, 2'b10};
    vecs[6]  = '{5, 0, 1, 0,  0,  0, 5, 1,  0, 0,  0, 0, 0, 5'b00111, 3'b010, 2'b00, 2'b00};
    vecs[7]  = '{0, 5, 0, 0,  0,  0, 5, 1,  0, 0,  0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[8]  = '{0, 5, 0, 1,  0,  0, 5, 1,  0, 0,  0, 0, 0, 5'b00111, 3'b010, 2'b00, 2'b00};
    vecs[9]  = '{0, 0, 1, 1,  0,  0, 0, 1,  0, 0,  0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[10] = '{5, 0, 1, 0,  0,  0, 5, 1,  0, 0,  0, 0, 1, 5'b11111, 3'b111, 2'b00, 2'b00};
    vecs[11] = '{5, 0, 1, 0,  0,  0, 5, 0,  0, 0,  0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[12] = '{0, 0, 0, 0,  6,  0, 0, 0,  6, 0,  6, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[13] = '{0, 0, 0, 0, 31, 30, 0, 0, 31, 1, 30, 1, 0, 5'b11111, 3'b000, 2'b10, 2'b01};

    rst = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    chk("por_state", state, 2'd0);
    chk("por_timeout", mem_timeout, 1'b0);
    chk("por_stall_cnt", stall_cnt, 32'd0);
    chk("por_flush_cnt", flush_cnt, 32'd0);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
      id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
      ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2; ex_rd = vecs[i].ex_rd;
      ex_memread = vecs[i].memread;
      mem_rd = vecs[i].mem_rd; mem_regwrite = vecs[i].mem_rw;
      wb_rd = vecs[i].wb_rd; wb_regwrite = vecs[i].wb_rw;
      br_taken = vecs[i].br;
      cyc_begin();
      chk($sformatf("vec%0d_en", i), dut_en(), vecs[i].exp_en);
      chk($sformatf("vec%0d_flush", i), dut_fl(), vecs[i].exp_fl);
      chk($sformatf("vec%0d_fwd_a", i), fwd_a, vecs[i].exp_fa);
      chk($sformatf("vec%0d_fwd_b", i), fwd_b, vecs[i].exp_fb);
      cyc_end();
    end

    // Load-use: one bubble, then the pipe flows again
    clear_inputs();
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    cyc_begin();
    chk("lu_en", dut_en(), 5'b00111);
    chk("lu_flush", dut_fl(), 3'b010);
    cyc_end();
    ex_memread = 0; ex_rd = 0;
    cyc_begin();
    chk("lu_next_en", dut_en(), 5'b11111);
    chk("lu_next_flush", dut_fl(), 3'b000);
    cyc_end();

    // Short memory wait: four busy cycles
    clear_inputs();
    dmem_busy = 1;
    for (int k = 0; k < 4; k++) begin
      cyc_begin();
      chk($sformatf("wait4_state%0d", k), state, (k == 0) ? 2'd0 : 2'd1);
      chk($sformatf("wait4_en%0d", k), dut_en(), 5'b00000);
      cyc_end();
    end
    dmem_busy = 0;
    cyc_begin();
    chk("wait4_release_state", state, 2'd1);
    chk("wait4_release_en", dut_en(), 5'b11111);
    cyc_end();
    cyc_begin();
    chk("wait4_back_run", state, 2'd0);
    chk("wait4_no_timeout", mem_timeout, 1'b0);
    cyc_end();

    // Long memory wait: timeout appears in the WAIT_MAX-th wait cycle and sticks
    dmem_busy = 1;
    for (int k = 0; k < 20; k++) begin
      cyc_begin();
      chk($sformatf("to_flag%0d", k), mem_timeout, (k >= WAIT_MAX) ? 1'b1 : 1'b0);
      cyc_end();
    end
    dmem_busy = 0;
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      chk($sformatf("to_sticky%0d", k), mem_timeout, 1'b1);
      cyc_end();
    end

    // Asynchronous reset in the middle of MEM_WAIT, away from any clock edge
    dmem_busy = 1;
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      cyc_end();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", state, 2'd0);
    chk("async_rst_timeout", mem_timeout, 1'b0);
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Halt: DRAIN_CYCLES drain cycles then HALTED, branch cannot revive it
    id_halt = 1;
    cyc_begin();
    chk("halt_en", dut_en(), 5'b00111);
    chk("halt_flush", dut_fl(), 3'b010);
    cyc_end();
    id_halt = 0;
    for (int k = 0; k < DRAIN_CYCLES; k++) begin
      cyc_begin();
      chk($sformatf("drain_state%0d", k), state, 2'd2);
      chk($sformatf("drain_en%0d", k), dut_en(), 5'b00111);
      cyc_end();
    end
    br_taken = 1;
    for (int k = 0; k < 2; k++) begin
      cyc_begin();
      chk($sformatf("halted_state%0d", k), state, 2'd3);
      chk($sformatf("halted_flag%0d", k), halted, 1'b1);
      chk($sformatf("halted_en%0d", k), dut_en(), 5'b00000);
      cyc_end();
    end
    do_reset();

    // Branch in the second drain cycle cancels the halt
    id_halt = 1;
    cyc_begin();
    cyc_end();
    id_halt = 0;
    cyc_begin();
    chk("hbr_drain1", state, 2'd2);
    cyc_end();
    br_taken = 1;
    cyc_begin();
    chk("hbr_state", state, 2'd2);
    chk("hbr_en", dut_en(), 5'b11111);
    chk("hbr_flush", dut_fl(), 3'b111);
    cyc_end();
    br_taken = 0;
    cyc_begin();
    chk("hbr_run", state, 2'd0);
    chk("hbr_run_en", dut_en(), 5'b11111);
    cyc_end();

    // Memory stall during DRAIN holds the drain count
    id_halt = 1;
    cyc_begin();
    cyc_end();
    id_halt = 0;
    cyc_begin();
    cyc_end();
    dmem_busy = 1;
    for (int k = 0; k < 2; k++) begin
      cyc_begin();
      chk($sformatf("dbusy_state%0d", k), state, 2'd2);
      chk($sformatf("dbusy_en%0d", k), dut_en(), 5'b00000);
      cyc_end();
    end
    dmem_busy = 0;
    for (int k = 0; k < DRAIN_CYCLES - 1; k++) begin
      cyc_begin();
      chk($sformatf("dbusy_rest%0d", k), state, 2'd2);
      cyc_end();
    end
    cyc_begin();
    chk("dbusy_halted", state, 2'd3);
    cyc_end();
    do_reset();

    // Randomized traffic against the reference model
    begin
      int burst = 0;
      for (int n = 0; n < 4000; n++) begin
        if ((m_mode == 3 && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0)
          do_reset();
        id_rs1 = 5'($urandom_range(0, 7));
        id_rs2 = 5'($urandom_range(0, 7));
        id_use_rs1 = 1'($urandom_range(0, 1));
        id_use_rs2 = 1'($urandom_range(0, 1));
        id_halt = ($urandom_range(0, 29) == 0);
        ex_rs1 = 5'($urandom_range(0, 7));
        ex_rs2 = 5'($urandom_range(0, 7));
        ex_rd = 5'($urandom_range(0, 7));
        ex_memread = ($urandom_range(0, 2) == 0);
        mem_rd = 5'($urandom_range(0, 7));
        mem_regwrite = 1'($urandom_range(0, 1));
        wb_rd = 5'($urandom_range(0, 7));
        wb_regwrite = 1'($urandom_range(0, 1));
        br_taken = ($urandom_range(0, 9) == 0);
        if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(1, 20);
        dmem_busy = (burst > 0);
        if (burst > 0) burst--;
        cyc_begin();
        cyc_end();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It generates per-stage write-enable and flush controls for the PC and the four pipeline registers, and EX-stage operand forwarding selects. It also runs a small FSM for three cases: multi-cycle data-memory waits, a controlled halt/drain, and a sticky memory-timeout error. Branches and jumps resolve in MEM.

Parameters:
WAIT_MAX, 15, cycles in MEM_WAIT before mem_timeout sets (1..255)
DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED (1..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs1, id_rs2  in  5  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
id_halt  in  1  ID instruction is a halt (ecall)
ex_rs1, ex_rs2  in  5  source registers in ID/EX
ex_rd  in  5  destination in ID/EX
ex_memread  in  1  ID/EX instruction is a load
mem_rd  in  5  destination in EX/MEM
mem_regwrite  in  1  EX/MEM writes a register
wb_rd  in  5  destination in MEM/WB
wb_regwrite  in  1  MEM/WB writes a register
br_taken  in  1  branch/jump in MEM is taken (PC mux selects target)
dmem_busy  in  1  data memory not ready this cycle
pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1  register enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1  load bubble (all-zero) on next edge
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
state  out  2  0 RUN, 1 MEM_WAIT, 2 DRAIN, 3 HALTED
halted  out  1  high in HALTED
mem_timeout  out  1  sticky timeout error
stall_cnt, flush_cnt  out  32  performance counters

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset: state=RUN, wait/drain counters=0, mem_timeout=0, counters=0.
- Enables, flushes and forwarding are combinational from state and inputs. State and counters are registered.
- Forwarding, independent of state:
  - fwd_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1.
  - Else fwd_a=01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1.
  - Else fwd_a=00.
  - fwd_b is the same using ex_rs2.
- load_use = ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- RUN, in priority order:
  1. dmem_busy: all enables 0, no flushes; next MEM_WAIT, wait_cnt=1.
  2. br_taken: all enables 1, if_id/id_ex/ex_mem flush=1; stay RUN.
  3. load_use: pc_we=if_id_we=0, id_ex_flush=1, others enable 1; stay RUN. Exactly 1 bubble.
  4. id_halt: pc_we=if_id_we=0, id_ex_flush=1 (halt discarded); next DRAIN, drain_cnt=0.
  5. Otherwise all enables 1, no flushes.
- MEM_WAIT:
  - All enables 0, no flushes. Forwarding outputs hold because the inputs are frozen.
  - wait_cnt increments, saturating at 255.
  - When wait_cnt reaches WAIT_MAX with dmem_busy still 1, mem_timeout sets. It is cleared only by rst.
  - dmem_busy=0: next RUN. That cycle behaves as RUN rules 2-5.
- DRAIN:
  - Normal cycle: pc_we=if_id_we=0, id_ex_flush=1, ex_mem_we=mem_wb_we=1. drain_cnt increments; at DRAIN_CYCLES-1, next HALTED.
  - dmem_busy: all enables 0, drain_cnt holds, stay DRAIN.
  - br_taken: an older taken branch cancels the halt. Apply the RUN branch flush; next RUN.
- HALTED: all enables 0, halted=1, no exit except rst.
- br_taken and dmem_busy are never both high (single MEM instruction). If both are high, dmem_busy wins.
- rst asserted in any state returns to RUN within the same cycle (asynchronous).

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined:
  - stall_cnt increments on every cycle with pc_we=0 in RUN/MEM_WAIT.
  - flush_cnt increments on every br_taken flush.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_we=0, if_id_we=0, id_ex_flush=1; next cycle all enables 1.
- Forward priority: mem_rd=wb_rd=ex_rs1=7, both regwrite=1 -> fwd_a=10. With mem_rd=0 -> fwd_a=01. With rd=x0 on both -> 00.
- Memory wait: dmem_busy high 4 cycles -> state=1 for 4 cycles, all enables 0, then RUN. With WAIT_MAX=15 and busy 20 cycles -> mem_timeout=1 from the 15th wait cycle until rst.
- Branch: br_taken=1 in RUN -> if_id/id_ex/ex_mem flush=1 for 1 cycle, pc_we=1; flush_cnt+1 (PIPE_PERF_CNT_EN).
- Halt: id_halt=1 -> DRAIN for 3 cycles, then state=3, halted=1. br_taken in 2nd DRAIN cycle -> state=0, flushes asserted.
- Async reset: rst pulse mid-MEM_WAIT, not clock-aligned -> state=0 and mem_timeout=0 immediately.
